// File: rtl/stream_keygen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stream_keygen_ctrl
// Purpose  : Job-level control FSM for the chaotic-map keystream generator.
//            Sequences seed load, map warm-up (discarded iterations) and a
//            keystream run of a requested word count on one of NUM_CH map
//            datapath channels, then returns to idle. Supports abort,
//            downstream ready/valid backpressure and channel selection.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       clock
//   reset        in   1       synchronous, active-high reset
//   start_i      in   1       job request, sampled only in IDLE
//   len_i        in   LEN_W   keystream words for the job (latched on start)
//   ch_sel_i     in   CH_W    target channel (latched on start)
//   abort_i      in   1       cancel the current job
//   ks_ready_i   in   1       downstream accepts a keystream word
//   read_seed_o  out  1       seed/key register load enable
//   map_en_o     out  1       chaotic map iterate enable
//   sel_s_o      out  1       map input mux: 0 = seed, 1 = feedback
//   ks_valid_o   out  1       keystream word valid
//   ch_en_o      out  NUM_CH  one-hot channel enable
//   busy_o       out  1       job in progress
//   done_o       out  1       one-cycle pulse: job completed
//   aborted_o    out  1       one-cycle pulse: job cancelled
//   err_o        out  1       one-cycle pulse: start rejected (bad channel)
//   word_cnt_o   out  LEN_W   words handed off in the current job
// ============================================================================
module stream_keygen_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int LEN_W      = 16,
  parameter int LOAD_CYC   = 2,
  parameter int WARMUP_CYC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [CH_W-1:0]   ch_sel_i,
  input  logic              abort_i,
  input  logic              ks_ready_i,
  output logic              read_seed_o,
  output logic              map_en_o,
  output logic              sel_s_o,
  output logic              ks_valid_o,
  output logic [NUM_CH-1:0] ch_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  word_cnt_o
);

  // One shared phase counter covers both LOAD and WARM; it only has to count
  // up to the longer of the two durations.
  localparam int c_MAX_CYC = (LOAD_CYC > WARMUP_CYC) ? LOAD_CYC : WARMUP_CYC;
  localparam int c_CNT_W   = (c_MAX_CYC < 2) ? 1 : $clog2(c_MAX_CYC);

  localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CNT_W'(LOAD_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_WARM_LAST =
    c_CNT_W'((WARMUP_CYC > 0) ? (WARMUP_CYC - 1) : 0);
  localparam logic               c_SKIP_WARM = (WARMUP_CYC == 0);
  // One extra bit so NUM_CH == 2**CH_W is representable.
  localparam logic [CH_W:0]      c_NUM_CH    = (CH_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WARM = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [c_CNT_W-1:0] cyc_q, cyc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic               err_q, err_d;

  logic               w_ch_ok;
  logic               w_abortable;

  assign w_ch_ok     = ({1'b0, ch_sel_i} < c_NUM_CH);
  assign w_abortable = (state_q == ST_LOAD) || (state_q == ST_WARM) ||
                       (state_q == ST_RUN);

  // --------------------------------------------------------------------------
  // State / counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      len_q      <= '0;
      ch_q       <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      len_q      <= len_d;
      ch_q       <= ch_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    len_d       = len_q;
    ch_d        = ch_q;
    word_cnt_d  = word_cnt_q;
    err_d       = 1'b0;
    read_seed_o = 1'b0;
    map_en_o    = 1'b0;
    sel_s_o     = 1'b0;
    ks_valid_o  = 1'b0;
    done_o      = 1'b0;
    aborted_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (w_ch_ok) begin
            len_d      = len_i;
            ch_d       = ch_sel_i;
            word_cnt_d = '0;
            cyc_d      = '0;
            // A zero-length job skips the datapath entirely.
            state_d    = (len_i == '0) ? ST_DONE : ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        read_seed_o = 1'b1;
        if (cyc_q == c_LOAD_LAST) begin
          cyc_d   = '0;
          state_d = c_SKIP_WARM ? ST_RUN : ST_WARM;
        end else begin
          cyc_d = cyc_q + c_CNT_W'(1);
        end
      end

      ST_WARM: begin
        map_en_o = 1'b1;
        sel_s_o  = 1'b1;
        if (cyc_q == c_WARM_LAST) begin
          cyc_d   = '0;
          state_d = ST_RUN;
        end else begin
          cyc_d = cyc_q + c_CNT_W'(1);
        end
      end

      ST_RUN: begin
        sel_s_o    = 1'b1;
        ks_valid_o = 1'b1;
        // The map only advances when the current word is taken downstream.
        map_en_o   = ks_ready_i;
        if (ks_ready_i) begin
          word_cnt_d = word_cnt_q + LEN_W'(1);
          if (word_cnt_q == (len_q - LEN_W'(1))) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any transition chosen above, including completion.
    if (abort_i && w_abortable) begin
      aborted_o = 1'b1;
      state_d   = ST_IDLE;
      cyc_d     = '0;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;
  assign word_cnt_o = word_cnt_q;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch_en
      assign ch_en_o[i] = busy_o && (ch_q == CH_W'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stream_keygen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_keygen_ctrl
// Purpose  : Self-checking bench for stream_keygen_ctrl. A job-level model
//            derives, for every cycle, the expected control outputs and the
//            expected handshake/done/abort/err events; a monitor compares the
//            DUT against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_keygen_ctrl;

  localparam int NUM_CH     = 3;
  localparam int CH_W       = 2;
  localparam int LEN_W      = 16;
  localparam int LOAD_CYC   = 2;
  localparam int WARMUP_CYC = 3;
  localparam int VW         = 6 + NUM_CH;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_WARM = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_DONE = 4;

  localparam int EV_WORD  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_ABORT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_i = 1'b0;
  logic [LEN_W-1:0]  len_i = '0;
  logic [CH_W-1:0]   ch_sel_i = '0;
  logic              abort_i = 1'b0;
  logic              ks_ready_i = 1'b0;
  logic              read_seed_o, map_en_o, sel_s_o, ks_valid_o;
  logic [NUM_CH-1:0] ch_en_o;
  logic              busy_o, done_o, aborted_o, err_o;
  logic [LEN_W-1:0]  word_cnt_o;

  stream_keygen_ctrl #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .LEN_W(LEN_W),
    .LOAD_CYC(LOAD_CYC), .WARMUP_CYC(WARMUP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i),
    .ch_sel_i(ch_sel_i), .abort_i(abort_i), .ks_ready_i(ks_ready_i),
    .read_seed_o(read_seed_o), .map_en_o(map_en_o), .sel_s_o(sel_s_o),
    .ks_valid_o(ks_valid_o), .ch_en_o(ch_en_o), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o), .err_o(err_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int val;
    int ch;
  } ev_t;

  ev_t              exp_q[$];
  logic [VW-1:0]    exp_vec[int];
  int               exp_wc[int];
  bit               sim_done = 1'b0;
  int               checks = 0;
  int               errors = 0;

  // Expected {read_seed,map_en,sel_s,ks_valid,busy,done,ch_en} for a phase.
  function automatic logic [VW-1:0] vec_of(input int ph, input bit rdy, input int ch);
    logic [NUM_CH-1:0] oh;
    logic [5:0]        c;
    oh = '0;
    c  = '0;
    if (ph != PH_IDLE) oh[ch] = 1'b1;
    case (ph)
      PH_LOAD: c = 6'b100010;
      PH_WARM: c = 6'b011010;
      PH_RUN:  c = {1'b0, rdy, 1'b1, 1'b1, 1'b1, 1'b0};
      PH_DONE: c = 6'b000011;
      default: c = 6'b000000;
    endcase
    return {c, oh};
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (always entered just after a rising edge)
  // --------------------------------------------------------------------------
  // mode: 0 random ready, 1 ready always, 2 ready low at offsets 7 and 8.
  // cut_kind: 0 none, 1 abort at start+cut_off, 2 reset at start+cut_off.
  task automatic run_job(input int len, input int ch, input int mode,
                         input int cut_off, input int cut_kind);
    int   n, c, cnt, donec, endc, x, kind;
    bit   rdy[];
    int   ph[];
    int   wc[];
    ev_t  loc[$];
    ev_t  e;
    n    = cyc;
    kind = cut_kind;
    rdy  = new[700];
    ph   = new[700];
    wc   = new[700];
    foreach (rdy[k]) begin
      case (mode)
        1:       rdy[k] = 1'b1;
        2:       rdy[k] = !(k == 7 || k == 8);
        default: rdy[k] = (k >= 300) ? 1'b1 : ($urandom_range(0, 9) < 7);
      endcase
      ph[k] = PH_IDLE;
      wc[k] = 0;
    end
    if (len == 0) begin
      donec = n + 1;
    end else begin
      for (int k = 1; k <= LOAD_CYC; k++) ph[k] = PH_LOAD;
      for (int k = LOAD_CYC + 1; k <= LOAD_CYC + WARMUP_CYC; k++) ph[k] = PH_WARM;
      cnt = 0;
      c   = n + 1 + LOAD_CYC + WARMUP_CYC;
      while (cnt < len) begin
        ph[c - n] = PH_RUN;
        wc[c - n] = cnt;
        if (rdy[c - n]) begin
          e = '{EV_WORD, c, cnt, ch};
          loc.push_back(e);
          cnt++;
        end
        c++;
      end
      donec = c;
    end
    ph[donec - n] = PH_DONE;
    wc[donec - n] = len;
    e = '{EV_DONE, donec, len, ch};
    loc.push_back(e);

    endc = donec;
    x    = n + cut_off;
    if (kind != 0 && len > 0 && cut_off >= 1 && x < donec) begin
      endc = x;
      while (loc.size() > 0 && loc[loc.size() - 1].cyc > x) void'(loc.pop_back());
      if (kind == 1) begin
        e = '{EV_ABORT, x, 0, ch};
        loc.push_back(e);
      end
    end else begin
      kind = 0;
    end
    foreach (loc[k]) exp_q.push_back(loc[k]);

    for (c = n; c <= endc; c++) begin
      exp_vec[c] = vec_of(ph[c - n], rdy[c - n], ch);
      if (c > n) exp_wc[c] = wc[c - n];
      ks_ready_i = rdy[c - n];
      if (c == n) begin
        start_i  = 1'b1;
        len_i    = LEN_W'(len);
        ch_sel_i = CH_W'(ch);
        abort_i  = 1'($urandom_range(0, 1));
      end else begin
        start_i  = ($urandom_range(0, 2) == 0);
        len_i    = LEN_W'($urandom_range(0, 20));
        ch_sel_i = CH_W'($urandom_range(0, 3));
        abort_i  = (kind == 1 && c == x) || (c == donec && $urandom_range(0, 1) == 1);
      end
      reset = (kind == 2 && c == x);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    reset   = 1'b0;
    if (kind == 2) exp_wc[cyc] = 0;
  endtask

  task automatic err_job();
    ev_t e;
    exp_vec[cyc] = '0;
    start_i  = 1'b1;
    ch_sel_i = CH_W'(3);
    len_i    = LEN_W'($urandom_range(0, 20));
    e = '{EV_ERR, cyc + 1, 0, 3};
    exp_q.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0;
    exp_vec[cyc] = '0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      exp_vec[cyc] = '0;
      start_i    = 1'b0;
      abort_i    = 1'($urandom_range(0, 1));
      ks_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    abort_i = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int len, ch, kind, off;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      exp_vec[cyc] = '0;
      exp_wc[cyc]  = 0;
    end
    reset = 1'b0;
    idle(2);

    run_job(4, 2, 1, 0, 0);                              // nominal timing
    idle(2);
    run_job(4, 2, 2, 0, 0);                              // ready low t7-t8
    idle(1);
    run_job(4, 2, 1, 4, 1);                              // abort in WARM
    idle(2);
    run_job(0, 1, 1, 0, 0);                              // zero-length job
    idle(1);
    err_job();                                           // bad channel
    idle(2);
    run_job(6, 0, 1, 1 + LOAD_CYC + WARMUP_CYC + 2, 2);  // reset mid-RUN
    run_job(3, 1, 1, 0, 0);                              // fresh job after reset
    run_job(1, 0, 1, 0, 0);                              // back-to-back, len 1

    for (int j = 0; j < 40; j++) begin
      len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) begin
        err_job();
      end else begin
        kind = $urandom_range(0, 9);
        kind = (kind < 6) ? 0 : ((kind < 8) ? 1 : 2);
        off  = $urandom_range(1, 1 + LOAD_CYC + WARMUP_CYC + len + 4);
        ch   = $urandom_range(0, NUM_CH - 1);
        run_job(len, ch, 0, off, kind);
      end
      idle($urandom_range(0, 3));
    end
    idle(3);
    sim_done = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  task automatic take_ev(input int kind, input int c, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{-1, -1, 0, 0};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event_unexpected cyc=%0d got kind=%0d required none", c, kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != c) begin
        errors++;
        $display("FAIL event_order got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                 kind, c, e.kind, e.cyc);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  initial begin
    logic [VW-1:0] act;
    ev_t           e;
    bit            ok;
    int            c;
    while (!sim_done) begin
      @(negedge clk);
      c   = cyc;
      act = {read_seed_o, map_en_o, sel_s_o, ks_valid_o, busy_o, done_o, ch_en_o};
      if (exp_vec.exists(c)) begin
        checks++;
        if (act !== exp_vec[c]) begin
          errors++;
          $display("FAIL ctrl_outputs cyc=%0d got=%b required=%b", c, act, exp_vec[c]);
        end
      end
      if (exp_wc.exists(c)) begin
        checks++;
        if (word_cnt_o !== LEN_W'(exp_wc[c])) begin
          errors++;
          $display("FAIL word_cnt cyc=%0d got=%0d required=%0d", c, word_cnt_o, exp_wc[c]);
        end
      end
      if (ks_valid_o === 1'b1 && ks_ready_i === 1'b1) begin
        take_ev(EV_WORD, c, e, ok);
        if (ok) begin
          checks++;
          if (word_cnt_o !== LEN_W'(e.val)) begin
            errors++;
            $display("FAIL word_index cyc=%0d got=%0d required=%0d", c, word_cnt_o, e.val);
          end
        end
      end
      if (aborted_o === 1'b1) take_ev(EV_ABORT, c, e, ok);
      if (done_o === 1'b1) begin
        take_ev(EV_DONE, c, e, ok);
        if (ok) begin
          checks++;
          if (word_cnt_o !== LEN_W'(e.val)) begin
            errors++;
            $display("FAIL done_count cyc=%0d got=%0d required=%0d", c, word_cnt_o, e.val);
          end
        end
      end
      if (err_o === 1'b1) take_ev(EV_ERR, c, e, ok);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL event_missing got none required kind=%0d cyc=%0d", e.kind, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
